// File: rtl/sipo_rx.sv
// rtl/sipo_rx.sv - serial-in parallel-out frame receiver with optional even parity
//
// Receives frames of the form: start bit (1), WIDTH data bits LSB-first, then an
// optional even-parity bit. Each completed word is presented on a valid/ready port
// backed by a one-entry holding register. The idle line level is 0.
//
// Ports:
//   clk       - single clock, rising-edge sampling
//   reset     - asynchronous active-high reset
//   si_en     - bit qualifier; si is sampled only when si_en=1
//   si        - serial data in
//   po        - received word, bit 0 = first data bit received
//   po_valid  - po/par_err hold a word not yet accepted
//   po_ready  - consumer accepts the word on an edge with po_valid && po_ready
//   par_err   - parity mismatch for the word on po (0 when PARITY_EN=0)
//   overrun   - one-cycle pulse: a completed frame was dropped (holding reg full)
//   busy      - high while a frame is being received
module sipo_rx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             si_en,
  input  logic             si,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             par_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] po_q, po_d;
  logic             po_valid_q, po_valid_d;
  logic             par_err_q, par_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] shifted;
  logic             frame_done;
  logic [WIDTH-1:0] frame_word;
  logic             frame_perr;
  logic             can_load;

  always_comb begin
    // New bit enters at the MSB so that after WIDTH shifts the first bit sits at bit 0.
    shifted            = sr_q >> 1;
    shifted[WIDTH-1]   = si;

    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    frame_done = 1'b0;
    frame_word = sr_q;
    frame_perr = 1'b0;

    if (si_en) begin
      case (state_q)
        IDLE: begin
          if (si) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          sr_d  = shifted;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
            end else begin
              state_d    = IDLE;
              frame_done = 1'b1;
              frame_word = shifted;
            end
          end
        end
        PARITY: begin
          state_d    = IDLE;
          frame_done = 1'b1;
          frame_word = sr_q;
          // Even parity: any odd total of ones across data and parity bit is an error.
          frame_perr = (^sr_q) ^ si;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    // Holding register: a drain on the same edge frees the slot for a completing frame.
    can_load   = !po_valid_q || po_ready;
    po_d       = po_q;
    par_err_d  = par_err_q;
    po_valid_d = po_valid_q && !po_ready;
    overrun_d  = 1'b0;

    if (frame_done) begin
      if (can_load) begin
        po_d       = frame_word;
        par_err_d  = frame_perr;
        po_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      po_q       <= '0;
      po_valid_q <= 1'b0;
      par_err_q  <= 1'b0;
      overrun_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      po_q       <= po_d;
      po_valid_q <= po_valid_d;
      par_err_q  <= par_err_d;
      overrun_q  <= overrun_d;
      busy_q     <= busy_d;
    end
  end

  assign po       = po_q;
  assign po_valid = po_valid_q;
  assign par_err  = par_err_q;
  assign overrun  = overrun_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_sipo_rx.sv
// tb/tb_sipo_rx.sv - self-checking bench for sipo_rx with and without parity
module tb_sipo_rx;

  logic       clk;
  logic       reset;
  logic       si_en;
  logic       si;
  logic       po_ready;

  logic [3:0] po1, po0;
  logic       po_valid1, po_valid0;
  logic       par_err1, par_err0;
  logic       overrun1, overrun0;
  logic       busy1, busy0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, index 0 = parity instance, index 1 = no-parity instance.
  int m_n[2];
  int m_v[2];
  int m_po[2];
  bit m_busy[2];
  bit m_valid[2];
  bit m_perr[2];
  bit m_ovr[2];

  sipo_rx #(.WIDTH(4), .PARITY_EN(1)) u_p1 (
    .clk(clk), .reset(reset), .si_en(si_en), .si(si),
    .po(po1), .po_valid(po_valid1), .po_ready(po_ready),
    .par_err(par_err1), .overrun(overrun1), .busy(busy1)
  );

  sipo_rx #(.WIDTH(4), .PARITY_EN(0)) u_p0 (
    .clk(clk), .reset(reset), .si_en(si_en), .si(si),
    .po(po0), .po_valid(po_valid0), .po_ready(po_ready),
    .par_err(par_err0), .overrun(overrun0), .busy(busy0)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_n[k] = 0; m_v[k] = 0; m_po[k] = 0;
      m_busy[k] = 0; m_valid[k] = 0; m_perr[k] = 0; m_ovr[k] = 0;
    end
  endtask

  // Frame-level model: collect qualified bits after a start bit; once the frame
  // length is reached, the low 4 bits are the word and the popcount gives parity.
  task automatic model_update(input int k, input bit en, input bit s, input bit rdy);
    int  p;
    bit  complete;
    bit  vpre;
    p        = (k == 0) ? 1 : 0;
    complete = 0;
    m_ovr[k] = 0;
    if (en) begin
      if (!m_busy[k]) begin
        if (s) begin
          m_busy[k] = 1; m_n[k] = 0; m_v[k] = 0;
        end
      end else begin
        m_v[k] = m_v[k] | (int'(s) << m_n[k]);
        m_n[k] = m_n[k] + 1;
        if (m_n[k] == 4 + p) begin
          complete  = 1;
          m_busy[k] = 0;
        end
      end
    end
    vpre = m_valid[k];
    if (vpre && rdy) m_valid[k] = 0;
    if (complete) begin
      if (!vpre || rdy) begin
        m_po[k]    = m_v[k] & 'hF;
        m_perr[k]  = (p == 1) ? ($countones(m_v[k]) % 2 == 1) : 1'b0;
        m_valid[k] = 1;
      end else begin
        m_ovr[k] = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("p1_po",       {28'b0, po1},       32'(m_po[0]));
    check("p1_po_valid", {31'b0, po_valid1}, {31'b0, m_valid[0]});
    check("p1_par_err",  {31'b0, par_err1},  {31'b0, m_perr[0]});
    check("p1_overrun",  {31'b0, overrun1},  {31'b0, m_ovr[0]});
    check("p1_busy",     {31'b0, busy1},     {31'b0, m_busy[0]});
    check("p0_po",       {28'b0, po0},       32'(m_po[1]));
    check("p0_po_valid", {31'b0, po_valid0}, {31'b0, m_valid[1]});
    check("p0_par_err",  {31'b0, par_err0},  {31'b0, m_perr[1]});
    check("p0_overrun",  {31'b0, overrun0},  {31'b0, m_ovr[1]});
    check("p0_busy",     {31'b0, busy0},     {31'b0, m_busy[1]});
  endtask

  task automatic tick(input bit en, input bit s, input bit rdy);
    si_en    = en;
    si       = s;
    po_ready = rdy;
    @(posedge clk);
    model_update(0, en, s, rdy);
    model_update(1, en, s, rdy);
    #1;
    compare_all();
  endtask

  task automatic send_frame(input logic [3:0] w, input bit par_bit, input bit rdy, input bit last_rdy);
    logic [3:0] wl;
    wl = w;
    tick(1, 1, rdy);
    for (int i = 0; i < 4; i++) tick(1, wl[i], rdy);
    tick(1, par_bit, last_rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #2;
    compare_all();
    check("rst_po",    {28'b0, po1}, 32'h0);
    check("rst_valid", {31'b0, po_valid1}, 32'h0);
    check("rst_busy",  {31'b0, busy1}, 32'h0);
    #3;
    reset = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    si_en    = 1'b0;
    si       = 1'b0;
    po_ready = 1'b0;
    model_reset();
    #3;
    compare_all();
    check("reset_po_valid", {31'b0, po_valid1}, 32'h0);
    #4;
    reset = 1'b0;

    // Basic frame 0xA with correct parity, then drain.
    send_frame(4'hA, 1'b0, 1'b0, 1'b0);
    check("basic_po",    {28'b0, po1}, 32'hA);
    check("basic_valid", {31'b0, po_valid1}, 32'h1);
    check("basic_perr",  {31'b0, par_err1}, 32'h0);
    tick(0, 0, 1);
    check("basic_drain", {31'b0, po_valid1}, 32'h0);

    // Parity error: data 0x7 with parity bit 0.
    send_frame(4'h7, 1'b0, 1'b0, 1'b0);
    check("perr_po",   {28'b0, po1}, 32'h7);
    check("perr_flag", {31'b0, par_err1}, 32'h1);

    // Idle zeros, then a stalled frame 0x5.
    for (int i = 0; i < 20; i++) tick(1, 0, 1);
    check("idle_busy",  {31'b0, busy1}, 32'h0);
    check("idle_valid", {31'b0, po_valid1}, 32'h0);
    tick(1, 1, 0);
    tick(1, 1, 0);
    tick(1, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, i[0], 0);
    check("stall_busy", {31'b0, busy1}, 32'h1);
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    check("stall_po",   {28'b0, po1}, 32'h5);
    check("stall_perr", {31'b0, par_err1}, 32'h0);

    // Overrun: 0x3 held, 0xC dropped.
    tick(0, 0, 1);
    send_frame(4'h3, 1'b0, 1'b0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b0, 1'b0);
    check("ovr_pulse", {31'b0, overrun1}, 32'h1);
    check("ovr_po",    {28'b0, po1}, 32'h3);
    tick(0, 0, 0);
    check("ovr_clear", {31'b0, overrun1}, 32'h0);
    tick(0, 0, 1);
    check("ovr_drain", {31'b0, po_valid1}, 32'h0);

    // Drain and completion on the same edge.
    send_frame(4'h3, 1'b0, 1'b0, 1'b0);
    send_frame(4'hC, 1'b0, 1'b0, 1'b1);
    check("sim_po",    {28'b0, po1}, 32'hC);
    check("sim_valid", {31'b0, po_valid1}, 32'h1);
    check("sim_ovr",   {31'b0, overrun1}, 32'h0);

    // Reset mid-frame, then 0x9.
    tick(1, 1, 1);
    tick(1, 1, 1);
    tick(1, 0, 1);
    do_reset();
    send_frame(4'h9, 1'b0, 1'b0, 1'b0);
    check("after_rst_po",   {28'b0, po1}, 32'h9);
    check("after_rst_perr", {31'b0, par_err1}, 32'h0);

    // No-parity instance: 1,1,0,0,1 gives 0x9 after the 5th edge.
    tick(0, 0, 1);
    for (int i = 0; i < 6; i++) tick(1, 0, 1);
    tick(1, 1, 0);
    tick(1, 1, 0);
    tick(1, 0, 0);
    tick(1, 0, 0);
    tick(1, 1, 0);
    check("np_po",    {28'b0, po0}, 32'h9);
    check("np_valid", {31'b0, po_valid0}, 32'h1);
    check("np_perr",  {31'b0, par_err0}, 32'h0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        tick($urandom_range(3) != 0, 1'($urandom), 1'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
